// File: rtl/cxl2_cache_d2h_req_arb.sv
// Purpose: round-robin arbiter for the CXL.cache D2H request channel. It stamps each grant with the lowest free CQID
//          and frees that CQID again when an H2D GO-class response names it.
// Latency: a request handshaken in cycle N is presented on d2h_req_* in cycle N+1 through one register slot.
// Backpressure: while d2h_req_ready_i is low the full slot holds its fields and no grants are made.
//               An empty CQID pool also blocks all grants.
// Option: defining CXL2_CACHE_CQID_CHK_EN makes the block ignore releases of free or out-of-range CQIDs
//         and latch those releases on err_o.
module cxl2_cache_d2h_req_arb #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_CQID = 16,
  parameter int CQW      = $clog2(NUM_CQID)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*5-1:0]  req_opcode_i,
  input  logic [NUM_REQ*46-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]    req_nt_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [CQW-1:0]        req_cqid_o,
  output logic                  d2h_req_valid_o,
  output logic [4:0]            d2h_req_opcode_o,
  output logic [45:0]           d2h_req_address_o,
  output logic [11:0]           d2h_req_cqid_o,
  output logic                  d2h_req_nt_o,
  input  logic                  d2h_req_ready_i,
  input  logic                  h2d_rsp_valid_i,
  input  logic [3:0]            h2d_rsp_opcode_i,
  input  logic [11:0]           h2d_rsp_cqid_i,
  output logic [CQW:0]          outstanding_o,
  output logic                  err_o
);

  localparam int RW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [4:0]     opcode;
    logic [45:0]    addr;
    logic [CQW-1:0] cqid;
    logic           nt;
  } slot_t;

  slot_t               slot_q;
  slot_t               slot_d;
  logic                slot_vld_q;
  logic [NUM_CQID-1:0] free_q;
  logic [NUM_CQID-1:0] free_d;
  logic [RW-1:0]       rr_ptr_q;
  logic [CQW:0]        cnt_q;
  logic [CQW:0]        cnt_d;

  logic                slot_avail;
  logic                pool_any;
  logic [CQW-1:0]      alloc_idx;
  logic                gnt_found;
  logic [RW-1:0]       gnt_idx;
  logic                grant;

  logic                rel_go;
  logic                rel_set;
  logic                rel_dec;
  logic                rel_was_free;
  logic [CQW-1:0]      rel_idx;
  logic [11:0]         rel_hi;

  assign slot_avail = ~slot_vld_q | d2h_req_ready_i;

  // Lowest-index free CQID, taken from the pool as it stands at the start of the cycle.
  always_comb begin
    alloc_idx = '0;
    pool_any  = 1'b0;
    for (int i = NUM_CQID - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        alloc_idx = CQW'(i);
        pool_any  = 1'b1;
      end
    end
  end

  // Round-robin pick: first pass covers requesters at or above rr_ptr, second pass wraps to those below it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!gnt_found && req_valid_i[r] && (RW'(r) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = RW'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!gnt_found && req_valid_i[r] && (RW'(r) < rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = RW'(r);
      end
    end
  end

  assign grant      = ~rst & slot_avail & pool_any & gnt_found;
  assign req_cqid_o = grant ? alloc_idx : '0;

  // One-hot ready toward the winning requester, together with its fields muxed into the slot load value.
  always_comb begin
    req_ready_o = '0;
    slot_d      = '0;
    slot_d.cqid = alloc_idx;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (RW'(r) == gnt_idx) begin
        req_ready_o[r] = grant;
        slot_d.opcode  = req_opcode_i[5*r +: 5];
        slot_d.addr    = req_addr_i[46*r +: 46];
        slot_d.nt      = req_nt_i[r];
      end
    end
  end

  // GO, GO_WRITE_PULL, GO_WRITE_PULL_DROP and GO_ERR_WRITE_PULL are the only responses that retire a CQID.
  assign rel_go = h2d_rsp_valid_i &
                  ((h2d_rsp_opcode_i == 4'b0100) | (h2d_rsp_opcode_i == 4'b0101) |
                   (h2d_rsp_opcode_i == 4'b1000) | (h2d_rsp_opcode_i == 4'b1111));
  assign rel_idx      = h2d_rsp_cqid_i[CQW-1:0];
  assign rel_hi       = h2d_rsp_cqid_i >> CQW;
  assign rel_was_free = free_q[rel_idx];

`ifdef CXL2_CACHE_CQID_CHK_EN
  logic rel_bad;
  logic err_q;

  assign rel_bad = rel_go & ((|rel_hi) | rel_was_free);
  assign rel_set = rel_go & ~rel_bad;
  assign rel_dec = rel_set;
  assign err_o   = err_q;

  // Sticky flag for releases that name a free or out-of-range CQID. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (rel_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_hi;

  // The count only drops when the bit was really allocated, so a stray GO cannot underflow it.
  assign rel_set   = rel_go;
  assign rel_dec   = rel_go & ~rel_was_free;
  assign unused_hi = |rel_hi;
  assign err_o     = 1'b0;
`endif

  // Release is applied before allocation, so a CQID that is granted this cycle always ends up marked busy.
  always_comb begin
    free_d = free_q;
    if (rel_set) begin
      free_d[rel_idx] = 1'b1;
    end
    if (grant) begin
      free_d[alloc_idx] = 1'b0;
    end
  end

  // The outstanding count moves by +1, -1 or 0 depending on which of allocation and release happen.
  always_comb begin
    case ({grant, rel_dec})
      2'b10:   cnt_d = cnt_q + (CQW+1)'(1);
      2'b01:   cnt_d = cnt_q - (CQW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pool, count and round-robin pointer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_q   <= '1;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      free_q <= free_d;
      cnt_q  <= cnt_d;
      if (grant) begin
        rr_ptr_q <= (gnt_idx == RW'(NUM_REQ - 1)) ? '0 : gnt_idx + RW'(1);
      end
    end
  end

  // Output slot: it loads on a grant, empties on a drain with no new grant, and holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q <= 1'b0;
      slot_q     <= '0;
    end else if (grant) begin
      slot_vld_q <= 1'b1;
      slot_q     <= slot_d;
    end else if (d2h_req_ready_i) begin
      slot_vld_q <= 1'b0;
    end
  end

  assign d2h_req_valid_o   = slot_vld_q;
  assign d2h_req_opcode_o  = slot_q.opcode;
  assign d2h_req_address_o = slot_q.addr;
  assign d2h_req_cqid_o    = 12'(slot_q.cqid);
  assign d2h_req_nt_o      = slot_q.nt;
  assign outstanding_o     = cnt_q;

endmodule

// File: tb/tb_cxl2_cache_d2h_req_arb.sv
// Bench for cxl2_cache_d2h_req_arb (NUM_REQ=4, NUM_CQID=16).
// Combines a vector table, directed corner-case sequences and a per-cycle reference model.
// The model keeps a scoreboard queue holding the expected D2H slot contents.
module tb_cxl2_cache_d2h_req_arb;

  localparam int NR = 4;
  localparam int NC = 16;
  localparam int CW = 4;
`ifdef CXL2_CACHE_CQID_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid_i;
  logic [NR*5-1:0]  req_opcode_i;
  logic [NR*46-1:0] req_addr_i;
  logic [NR-1:0]  req_nt_i;
  logic [NR-1:0]  req_ready_o;
  logic [CW-1:0]  req_cqid_o;
  logic           d2h_req_valid_o;
  logic [4:0]     d2h_req_opcode_o;
  logic [45:0]    d2h_req_address_o;
  logic [11:0]    d2h_req_cqid_o;
  logic           d2h_req_nt_o;
  logic           d2h_req_ready_i;
  logic           h2d_rsp_valid_i;
  logic [3:0]     h2d_rsp_opcode_i;
  logic [11:0]    h2d_rsp_cqid_i;
  logic [CW:0]    outstanding_o;
  logic           err_o;

  cxl2_cache_d2h_req_arb #(.NUM_REQ(NR), .NUM_CQID(NC)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_opcode_i(req_opcode_i), .req_addr_i(req_addr_i), .req_nt_i(req_nt_i),
    .req_ready_o(req_ready_o), .req_cqid_o(req_cqid_o),
    .d2h_req_valid_o(d2h_req_valid_o), .d2h_req_opcode_o(d2h_req_opcode_o),
    .d2h_req_address_o(d2h_req_address_o), .d2h_req_cqid_o(d2h_req_cqid_o),
    .d2h_req_nt_o(d2h_req_nt_o), .d2h_req_ready_i(d2h_req_ready_i),
    .h2d_rsp_valid_i(h2d_rsp_valid_i), .h2d_rsp_opcode_i(h2d_rsp_opcode_i), .h2d_rsp_cqid_i(h2d_rsp_cqid_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [45:0] addr;
    logic [11:0] cqid;
    logic        nt;
  } d2h_t;

  typedef struct {
    logic [3:0]  vld;
    logic        rdy;
    logic        rv;
    logic [3:0]  rop;
    logic [11:0] rcq;
    logic [3:0]  e_rdy;
    logic [3:0]  e_cq;
    int          e_out;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  logic [NC-1:0] m_free = '1;
  int            m_ptr  = 0;
  int            m_cnt  = 0;
  bit            m_err  = 1'b0;
  d2h_t          sbq[$];

  // outputs sampled at the falling edge of the most recent tick
  logic [3:0]  s_ready;
  logic [3:0]  s_cqid;
  logic        s_vld;
  logic [4:0]  s_out;
  logic        s_err;
  logic [11:0] s_d2h_cqid;
  logic [4:0]  s_op;
  logic [45:0] s_addr;
  logic        s_nt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample and check at negedge, advance the model at posedge, return 1 time unit after.
  task automatic tick();
    bit          avail, f_any, e_gnt, rel;
    int          f_idx, e_idx, ri;
    logic [3:0]  e_rdy, e_cq;
    logic [3:0]  c_vld;
    logic        c_rdy, c_rst, c_rv;
    logic [3:0]  c_rop;
    logic [11:0] c_rcq;
    d2h_t        ent;
    @(negedge clk);
    c_vld = req_valid_i; c_rdy = d2h_req_ready_i; c_rst = rst;
    c_rv = h2d_rsp_valid_i; c_rop = h2d_rsp_opcode_i; c_rcq = h2d_rsp_cqid_i;
    avail = (sbq.size() == 0) || c_rdy;
    f_any = 1'b0; f_idx = 0;
    for (int i = NC - 1; i >= 0; i--) if (m_free[i]) begin f_any = 1'b1; f_idx = i; end
    e_gnt = 1'b0; e_idx = 0;
    if (!c_rst && avail && f_any) begin
      for (int k = 0; k < NR; k++) begin
        int r;
        r = (m_ptr + k) % NR;
        if (!e_gnt && c_vld[r]) begin e_gnt = 1'b1; e_idx = r; end
      end
    end
    e_rdy = e_gnt ? (4'b0001 << e_idx) : 4'b0000;
    e_cq  = e_gnt ? 4'(f_idx) : 4'd0;
    check("model req_ready", req_ready_o, e_rdy);
    check("model req_cqid", req_cqid_o, e_cq);
    check("model d2h_valid", d2h_req_valid_o, sbq.size() > 0);
    if (sbq.size() > 0) begin
      check("sb opcode", d2h_req_opcode_o, sbq[0].op);
      check("sb address", d2h_req_address_o, sbq[0].addr);
      check("sb cqid", d2h_req_cqid_o, sbq[0].cqid);
      check("sb nt", d2h_req_nt_o, sbq[0].nt);
    end
    check("model outstanding", outstanding_o, 64'(m_cnt));
    check("model err", err_o, m_err);
    s_ready = req_ready_o; s_cqid = req_cqid_o; s_vld = d2h_req_valid_o; s_out = outstanding_o;
    s_err = err_o; s_d2h_cqid = d2h_req_cqid_o; s_op = d2h_req_opcode_o; s_addr = d2h_req_address_o;
    s_nt = d2h_req_nt_o;
    @(posedge clk);
    if (c_rst) begin
      m_free = '1; m_ptr = 0; m_cnt = 0; m_err = 1'b0; sbq.delete();
    end else begin
      if (sbq.size() != 0 && c_rdy) void'(sbq.pop_front());
      rel = c_rv && (c_rop == 4'b0100 || c_rop == 4'b0101 || c_rop == 4'b1000 || c_rop == 4'b1111);
      ri  = int'(c_rcq[3:0]);
      if (rel) begin
        if (CHK) begin
          if ((c_rcq[11:4] != 8'd0) || m_free[ri]) m_err = 1'b1;
          else begin m_free[ri] = 1'b1; m_cnt--; end
        end else begin
          if (!m_free[ri]) m_cnt--;
          m_free[ri] = 1'b1;
        end
      end
      if (e_gnt) begin
        m_free[f_idx] = 1'b0;
        m_cnt++;
        m_ptr = (e_idx + 1) % NR;
        ent.op = req_opcode_i[5*e_idx +: 5];
        ent.addr = req_addr_i[46*e_idx +: 46];
        ent.cqid = 12'(f_idx);
        ent.nt = req_nt_i[e_idx];
        sbq.push_back(ent);
      end
    end
    #1;
  endtask

  task automatic rsp(input logic v, input logic [3:0] op, input logic [11:0] cq);
    h2d_rsp_valid_i = v; h2d_rsp_opcode_i = op; h2d_rsp_cqid_i = cq;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid_i = '0; d2h_req_ready_i = 1'b1; rsp(1'b0, 4'h0, 12'h0);
    tick(); tick();
    rst = 1'b0;
  endtask

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid_i = '0; d2h_req_ready_i = 1'b1; rsp(1'b0, 4'h0, 12'h0);
    req_nt_i = 4'b1010;
    for (int r = 0; r < NR; r++) begin
      req_opcode_i[5*r +: 5] = 5'(r + 2);
      req_addr_i[46*r +: 46] = 46'(r + 1);
    end
    repeat (2) @(posedge clk);
    #1;

    // reset state
    do_reset();
    tick();
    check("reset d2h_valid", s_vld, 0);
    check("reset outstanding", s_out, 0);
    check("reset err", s_err, 0);
    check("reset d2h_cqid", s_d2h_cqid, 0);
    check("reset d2h_opcode", s_op, 0);
    check("reset d2h_addr", s_addr, 0);
    check("reset d2h_nt", s_nt, 0);

    // fairness, backpressure, releases and ignored opcodes; e_out is the count seen before the row's edge
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'h0, 12'h000, 4'b0001, 4'd0, 0};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 4'h0, 12'h000, 4'b0010, 4'd1, 1};
    tbl[2]  = '{4'hF, 1'b1, 1'b0, 4'h0, 12'h000, 4'b0100, 4'd2, 2};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'h0, 12'h000, 4'b1000, 4'd3, 3};
    tbl[4]  = '{4'hF, 1'b1, 1'b0, 4'h0, 12'h000, 4'b0001, 4'd4, 4};
    tbl[5]  = '{4'hF, 1'b0, 1'b0, 4'h0, 12'h000, 4'b0000, 4'd0, 5};
    tbl[6]  = '{4'hF, 1'b0, 1'b0, 4'h0, 12'h000, 4'b0000, 4'd0, 5};
    tbl[7]  = '{4'hF, 1'b0, 1'b0, 4'h0, 12'h000, 4'b0000, 4'd0, 5};
    tbl[8]  = '{4'hF, 1'b1, 1'b0, 4'h0, 12'h000, 4'b0010, 4'd5, 5};
    tbl[9]  = '{4'h0, 1'b1, 1'b1, 4'h4, 12'h002, 4'b0000, 4'd0, 6};
    tbl[10] = '{4'h1, 1'b1, 1'b0, 4'h0, 12'h000, 4'b0001, 4'd2, 5};
    tbl[11] = '{4'h0, 1'b1, 1'b1, 4'h1, 12'h000, 4'b0000, 4'd0, 6};
    tbl[12] = '{4'h2, 1'b1, 1'b1, 4'h5, 12'h000, 4'b0010, 4'd6, 6};
    tbl[13] = '{4'h4, 1'b1, 1'b1, 4'h8, 12'h001, 4'b0100, 4'd0, 6};
    tbl[14] = '{4'h8, 1'b1, 1'b1, 4'hF, 12'h003, 4'b1000, 4'd1, 6};
    tbl[15] = '{4'h0, 1'b1, 1'b1, 4'h6, 12'h004, 4'b0000, 4'd0, 6};
    tbl[16] = '{4'h5, 1'b1, 1'b0, 4'h0, 12'h000, 4'b0001, 4'd3, 6};
    tbl[17] = '{4'h5, 1'b1, 1'b0, 4'h0, 12'h000, 4'b0100, 4'd7, 7};
    for (int i = 0; i < 18; i++) begin
      req_valid_i = tbl[i].vld; d2h_req_ready_i = tbl[i].rdy;
      rsp(tbl[i].rv, tbl[i].rop, tbl[i].rcq);
      tick();
      check($sformatf("vec%0d ready", i), s_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d cqid", i), s_cqid, tbl[i].e_cq);
      check($sformatf("vec%0d outstanding", i), s_out, 64'(tbl[i].e_out));
    end

    // single RD_OWN request from requester 0
    do_reset();
    req_valid_i = 4'b0001;
    tick();
    check("single ready", s_ready, 4'b0001);
    req_valid_i = 4'b0000;
    tick();
    check("single d2h_valid", s_vld, 1);
    check("single d2h_cqid", s_d2h_cqid, 0);
    check("single d2h_opcode", s_op, 5'b00010);
    check("single d2h_addr", s_addr, 46'h1);
    check("single outstanding", s_out, 1);

    // pool exhaustion, then one GO re-enables a grant on the following cycle
    do_reset();
    req_valid_i = 4'b0001;
    repeat (16) tick();
    tick();
    check("exhaust ready", s_ready, 0);
    check("exhaust outstanding", s_out, 16);
    rsp(1'b1, 4'b0100, 12'd5);
    tick();
    check("exhaust release-cycle ready", s_ready, 0);
    rsp(1'b0, 4'h0, 12'h0);
    tick();
    check("exhaust regrant ready", s_ready, 4'b0001);
    check("exhaust regrant cqid", s_cqid, 5);
    check("exhaust after release outstanding", s_out, 15);
    req_valid_i = 4'b0000;
    tick();
    check("exhaust d2h_cqid", s_d2h_cqid, 5);
    check("exhaust final outstanding", s_out, 16);

    // simultaneous release of cqid 7 and a new grant
    do_reset();
    req_valid_i = 4'b0001;
    repeat (8) tick();
    req_valid_i = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      rsp(1'b1, 4'b0100, 12'(i));
      tick();
    end
    rsp(1'b0, 4'h0, 12'h0);
    tick();
    check("simul pre outstanding", s_out, 1);
    req_valid_i = 4'b0001;
    rsp(1'b1, 4'b0100, 12'd7);
    tick();
    check("simul grant cqid", s_cqid, 0);
    req_valid_i = 4'b0000;
    rsp(1'b0, 4'h0, 12'h0);
    tick();
    check("simul outstanding", s_out, 1);
    check("simul d2h_cqid", s_d2h_cqid, 0);

    // release of a free cqid, release with high CQID bits set, and clearing of err_o by reset
    do_reset();
    rsp(1'b1, 4'b0100, 12'd3);
    tick();
    check("freefree same-cycle err", s_err, 0);
    rsp(1'b0, 4'h0, 12'h0);
    tick();
    check("freefree err", s_err, CHK);
    check("freefree outstanding", s_out, 0);
    tick(); tick();
    check("freefree err sticky", s_err, CHK);
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = 4'b0000;
    tick();
    check("hibits pre outstanding", s_out, 1);
    rsp(1'b1, 4'b0100, 12'h010);
    tick();
    rsp(1'b0, 4'h0, 12'h0);
    tick();
    check("hibits outstanding", s_out, CHK ? 1 : 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("err cleared by reset", s_err, 0);

    // reset mid-operation, followed by a stale response for a pre-reset cqid
    do_reset();
    req_valid_i = 4'b1111;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("ready low during reset", s_ready, 0);
    tick();
    rst = 1'b0;
    req_valid_i = 4'b0000;
    rsp(1'b1, 4'b0100, 12'd1);
    tick();
    rsp(1'b0, 4'h0, 12'h0);
    tick();
    check("midreset outstanding", s_out, 0);
    check("midreset d2h_valid", s_vld, 0);
    check("midreset stale err", s_err, CHK);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cxl2_cache_d2h_req_arb.md
# cxl2_cache_d2h_req_arb

Round-robin arbiter and CQID allocator for the CXL.cache D2H request channel (CXL 2.0). It shares one D2H request port among NUM_REQ device-side requesters and stamps each granted request with a free CQID. It tracks outstanding CQIDs and releases them on H2D GO-class responses. It sits between the device cache agents and the CXL.cache link-layer packer.

## Interface
Parameters:
- NUM_REQ, 4: requester count, 2..8.
- NUM_CQID, 16: CQID pool size, power of 2, 2..4096.
- CQW, $clog2(NUM_CQID): internal CQID width.

Ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_opcode_i  in  NUM_REQ*5  D2H request opcode; requester r uses bits [5r+4:5r].
- req_addr_i  in  NUM_REQ*46  address[51:6]; requester r uses bits [46r+45:46r].
- req_nt_i  in  NUM_REQ  NT hint; 0 = default, 1 = LRU.
- req_ready_o  out  NUM_REQ  one-hot grant; handshake completes when valid and ready are both high.
- req_cqid_o  out  CQW  CQID assigned to the granted requester; meaningful only while any req_ready_o bit is high.
- d2h_req_valid_o  out  1  D2H request valid.
- d2h_req_opcode_o  out  5  opcode.
- d2h_req_address_o  out  46  address[51:6].
- d2h_req_cqid_o  out  12  CQID, zero-extended from CQW bits.
- d2h_req_nt_o  out  1  NT hint.
- d2h_req_ready_i  in  1  link packer accepts the request.
- h2d_rsp_valid_i  in  1  H2D response valid; always accepted, no backpressure.
- h2d_rsp_opcode_i  in  4  H2D response opcode.
- h2d_rsp_cqid_i  in  12  H2D response CQID; only bits [CQW-1:0] are used.
- outstanding_o  out  CQW+1  number of allocated CQIDs.
- err_o  out  1  sticky free-of-unallocated-CQID error.

## Operation
- Free pool: NUM_CQID-bit vector, 1 = free. Allocation picks the lowest-index free CQID.
- Output slot: one register stage holding opcode, address, cqid and nt, plus a valid bit.
- slot_avail = !d2h_req_valid_o | d2h_req_ready_i.
- A grant is possible when slot_avail is high, at least one CQID is free, and at least one req_valid_i bit is high.
- Grant selection: round-robin starting from rr_ptr. On a grant, rr_ptr moves to the index after the granted requester (wrapping NUM_REQ-1 to 0). With no grant, rr_ptr holds.
- On grant:
  - The slot loads the granted requester's fields and the allocated CQID; d2h_req_valid_o is set.
  - The CQID's free bit clears.
- On slot drain without a new grant, d2h_req_valid_o clears.
- Release: h2d_rsp_valid_i with an opcode of GO (4'b0100), GO_WRITE_PULL (4'b0101), GO_WRITE_PULL_DROP (4'b1000) or GO_ERR_WRITE_PULL (4'b1111) sets the free bit of h2d_rsp_cqid_i[CQW-1:0]. All other opcodes are ignored.
- Allocation and release in the same cycle:
  - Allocation sees the pool as it was at the start of the cycle, so a CQID being freed becomes allocatable next cycle.
  - outstanding_o changes by +1, -1 or 0 accordingly.
- A stalled slot (valid high, ready low) holds all fields stable and grants nothing.

## Timing
- Reset values: d2h_req_valid_o=0, all other d2h_req_* outputs 0, rr_ptr=0, pool all free, outstanding_o=0, err_o=0.
- req_ready_o and req_cqid_o are combinational from the current state and inputs. They are 0 while rst is high.
- Latency: a request handshaken in cycle N appears on d2h_req_valid_o in cycle N+1.
- Throughput: 1 request per cycle while d2h_req_ready_i=1 and CQIDs remain free.
- Pool empty: all req_ready_o bits are 0. The first release in cycle N allows a grant in cycle N+1.
- Reset mid-operation: all outstanding CQIDs are discarded and the pool returns to all free. Responses that arrive after reset for pre-reset CQIDs are treated as frees of unallocated IDs.

## Configuration
- CXL2_CACHE_CQID_CHK_EN defined:
  - A release of a CQID that is already free is ignored; the pool and count are unchanged.
  - That release sets err_o, which stays high until reset.
  - A release with nonzero h2d_rsp_cqid_i[11:CQW] also sets err_o and is ignored.
- CXL2_CACHE_CQID_CHK_EN undefined:
  - err_o is tied to 0.
  - Releases set the free bit unconditionally using the low CQW bits.
  - outstanding_o decrements only if the bit was previously clear, so the count never underflows.

## Test plan
- Single request: req 0 asserts RD_OWN (5'b00010) at address 46'h1 with ready_i=1 → next cycle d2h_req_valid_o=1, cqid=0, outstanding_o=1.
- Fairness: all 4 requesters held valid, ready_i=1 → grant order 0,1,2,3,0; CQIDs 0..4 issued in order.
- Exhaustion: NUM_CQID=16, 17 requests with no responses → 16 issued and req_ready_o=0. GO on cqid 5 in cycle N → 17th request granted in cycle N+1 with cqid 5.
- Backpressure: ready_i=0 for 3 cycles with the slot full → outputs stable, no grants; ready_i=1 → drain plus a new grant in the same cycle.
- Simultaneous: pool with only cqid 7 allocated; GO for cqid 7 in the same cycle as a new grant → grant receives cqid 0 and outstanding_o stays 1.
- With CXL2_CACHE_CQID_CHK_EN: GO on a free cqid 3 → err_o=1 from the next cycle onward; outstanding_o unchanged; err_o cleared only by rst.
